// File: rtl/servo_seq_pkg.sv
// Shared state encoding, AXI response codes and address helper
// for the servo register update sequencer.
package servo_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RDATA,
        FINISH
    } state_t;

    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam int unsigned REG_STRIDE = 4;
    localparam int unsigned TIMEOUT_W  = 8;

    function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [1:0] idx);
        return base + (32'(REG_STRIDE) * {30'd0, idx});
    endfunction

endpackage

// File: rtl/servo_update_sequencer.sv
// Writes latched setpoints to the servo register bank over AXI-Lite,
// reads each back, and reports write/read faults and readback mismatches.
module servo_update_sequencer
    import servo_seq_pkg::*;
#(
    parameter logic [31:0] C_BASE_ADDR = 32'h0000_0000,
    parameter int unsigned C_NUM_REGS  = 4,
    parameter int unsigned C_TIMEOUT   = 255
) (
    input  logic         ACLK,
    input  logic         ARESETN,
    input  logic         start,
    input  logic [127:0] servo_data,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [3:0]   mismatch,
    output logic [31:0]  M_AXI_AWADDR,
    output logic         M_AXI_AWVALID,
    input  logic         M_AXI_AWREADY,
    output logic [31:0]  M_AXI_WDATA,
    output logic [3:0]   M_AXI_WSTRB,
    output logic         M_AXI_WVALID,
    input  logic         M_AXI_WREADY,
    input  logic [1:0]   M_AXI_BRESP,
    input  logic         M_AXI_BVALID,
    output logic         M_AXI_BREADY,
    output logic [31:0]  M_AXI_ARADDR,
    output logic         M_AXI_ARVALID,
    input  logic         M_AXI_ARREADY,
    input  logic [31:0]  M_AXI_RDATA,
    input  logic [1:0]   M_AXI_RRESP,
    input  logic         M_AXI_RVALID,
    output logic         M_AXI_RREADY
);

    localparam logic [1:0]           LAST_IDX = 2'(C_NUM_REGS - 1);
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(C_TIMEOUT - 1);

    state_t               state;
    logic [1:0]           idx;
    logic [1:0]           nidx;
    logic [127:0]         data_q;
    logic [TIMEOUT_W-1:0] tmo;
    logic [31:0]          cur_word;
    logic [31:0]          next_word;
    logic                 aw_hs;
    logic                 w_hs;
    logic                 advance;
    logic                 wait_st;
    logic                 tmo_hit;

    assign M_AXI_WSTRB = 4'hF;
    assign nidx        = idx + 2'd1;
    assign cur_word    = data_q[{idx, 5'b0} +: 32];
    assign next_word   = data_q[{nidx, 5'b0} +: 32];
    assign aw_hs       = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_hs        = M_AXI_WVALID & M_AXI_WREADY;
    assign tmo_hit     = (tmo == TMO_LAST);
    assign wait_st     = state inside {WADDR, WRESP, RADDR, RDATA};

    // A VALID already low means its handshake finished in an earlier cycle.
    always_comb begin
        advance = 1'b0;
        unique case (state)
            WADDR:   advance = (!M_AXI_AWVALID || aw_hs) && (!M_AXI_WVALID || w_hs);
            WRESP:   advance = M_AXI_BVALID;
            RADDR:   advance = M_AXI_ARREADY;
            RDATA:   advance = M_AXI_RVALID;
            default: advance = 1'b0;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state         <= IDLE;
            idx           <= '0;
            data_q        <= '0;
            tmo           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            mismatch      <= '0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        data_q        <= servo_data;
                        idx           <= '0;
                        err           <= 1'b0;
                        mismatch      <= '0;
                        busy          <= 1'b1;
                        tmo           <= '0;
                        M_AXI_AWADDR  <= reg_addr(C_BASE_ADDR, 2'd0);
                        M_AXI_WDATA   <= servo_data[31:0];
                        M_AXI_AWVALID <= 1'b1;
                        M_AXI_WVALID  <= 1'b1;
                        state         <= WADDR;
                    end
                end
                WADDR: begin
                    if (aw_hs) M_AXI_AWVALID <= 1'b0;
                    if (w_hs)  M_AXI_WVALID  <= 1'b0;
                    if (advance) begin
                        M_AXI_BREADY <= 1'b1;
                        tmo          <= '0;
                        state        <= WRESP;
                    end
                end
                WRESP: begin
                    if (advance) begin
                        if (M_AXI_BRESP != RESP_OKAY) err <= 1'b1;
                        M_AXI_BREADY <= 1'b0;
                        tmo          <= '0;
                        if (idx == LAST_IDX) begin
                            idx           <= '0;
                            M_AXI_ARADDR  <= reg_addr(C_BASE_ADDR, 2'd0);
                            M_AXI_ARVALID <= 1'b1;
                            state         <= RADDR;
                        end else begin
                            idx           <= nidx;
                            M_AXI_AWADDR  <= reg_addr(C_BASE_ADDR, nidx);
                            M_AXI_WDATA   <= next_word;
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            state         <= WADDR;
                        end
                    end
                end
                RADDR: begin
                    if (advance) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        tmo           <= '0;
                        state         <= RDATA;
                    end
                end
                RDATA: begin
                    if (advance) begin
                        if (M_AXI_RRESP != RESP_OKAY) err <= 1'b1;
                        if (M_AXI_RDATA != cur_word) mismatch[idx] <= 1'b1;
                        M_AXI_RREADY <= 1'b0;
                        tmo          <= '0;
                        if (idx == LAST_IDX) begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            idx           <= nidx;
                            M_AXI_ARADDR  <= reg_addr(C_BASE_ADDR, nidx);
                            M_AXI_ARVALID <= 1'b1;
                            state         <= RADDR;
                        end
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    idx   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Stalled handshake: abandon the bus and finish with the fault flag set.
            if (wait_st && !advance) begin
                if (tmo_hit) begin
                    err           <= 1'b1;
                    M_AXI_AWVALID <= 1'b0;
                    M_AXI_WVALID  <= 1'b0;
                    M_AXI_BREADY  <= 1'b0;
                    M_AXI_ARVALID <= 1'b0;
                    M_AXI_RREADY  <= 1'b0;
                    done          <= 1'b1;
                    state         <= FINISH;
                end else begin
                    tmo <= tmo + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/servo_update_sequencer.md
SERVO_UPDATE_SEQUENCER -- requirements
Module: servo_update_sequencer

Interface
REQ-001 C_BASE_ADDR, 32'h0000_0000, byte address of servo register 0 in the servo register bank.
REQ-002 C_NUM_REGS, 4, number of servo registers handled per update (legal 1..4).
REQ-003 C_TIMEOUT, 255, maximum wait cycles per AXI handshake (8-bit).
REQ-004 ACLK  in  1  single clock; all logic on the rising edge.
REQ-005 ARESETN  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle update request.
REQ-007 servo_data  in  128  setpoint word i at [32i+31:32i].
REQ-008 busy  out  1  update in progress.
REQ-009 done  out  1  one-cycle pulse at the end of every update.
REQ-010 err  out  1  sticky fault flag for the last update.
REQ-011 mismatch  out  4  per-register readback-differs flag for the last update.
REQ-012 M_AXI_AWADDR  out  32  write address.
REQ-013 M_AXI_AWVALID  out  1  / M_AXI_AWREADY  in  1  write-address handshake.
REQ-014 M_AXI_WDATA  out  32  write data.
REQ-015 M_AXI_WSTRB  out  4  write strobes, always 4'hF.
REQ-016 M_AXI_WVALID  out  1  / M_AXI_WREADY  in  1  write-data handshake.
REQ-017 M_AXI_BRESP  in  2  write response.
REQ-018 M_AXI_BVALID  in  1  / M_AXI_BREADY  out  1  write-response handshake.
REQ-019 M_AXI_ARADDR  out  32  read address.
REQ-020 M_AXI_ARVALID  out  1  / M_AXI_ARREADY  in  1  read-address handshake.
REQ-021 M_AXI_RDATA  in  32  / M_AXI_RRESP  in  2  read data and response.
REQ-022 M_AXI_RVALID  in  1  / M_AXI_RREADY  out  1  read-data handshake.

Function
REQ-023 FSM states: IDLE, WADDR, WRESP, RADDR, RDATA, FINISH; index counter idx runs 0..C_NUM_REGS-1.
REQ-024 IDLE with start=1: latch servo_data, idx=0, clear err and mismatch, set busy=1, enter WADDR next cycle. start is ignored in every other state, including FINISH.
REQ-025 WADDR: assert AWVALID and WVALID in the same cycle, with AWADDR=C_BASE_ADDR+4*idx and WDATA=latched word idx.
- Each VALID drops independently in the cycle after its own VALID&&READY.
- Payload stays stable while any VALID is high.
- Enter WRESP once both handshakes have completed.
REQ-026 WRESP: BREADY=1; on BVALID, BRESP!=2'b00 sets err. If idx is last: idx=0, go to RADDR. Otherwise idx+1, go to WADDR.
REQ-027 RADDR: ARVALID=1 with ARADDR=C_BASE_ADDR+4*idx; on ARREADY, go to RDATA.
REQ-028 RDATA: RREADY=1; on RVALID:
- RRESP!=2'b00 sets err.
- RDATA differing from latched word idx sets mismatch[idx].
- Last idx goes to FINISH; otherwise idx+1, go to RADDR.
REQ-029 A write or read error does not abort the update; all C_NUM_REGS writes and reads are always attempted.
REQ-030 FINISH: done=1 for exactly one cycle, busy=0 from the next cycle, return to IDLE. busy covers the cycle after start through FINISH.
REQ-031 No bubble cycles: each state advances in the cycle its handshake completes.
REQ-032 Timeout counter:
- Cleared on state entry; increments each wait cycle in WADDR/WRESP/RADDR/RDATA.
- On reaching C_TIMEOUT: err=1, all VALID/READY outputs forced to 0 next cycle, go to FINISH (fault recovery).
REQ-033 mismatch bits at or above C_NUM_REGS stay 0.

Reset
REQ-034 ARESETN low asynchronously forces state=IDLE, idx=0, and all VALID/READY, busy, done, err and mismatch to 0, including mid-transaction; the current update is abandoned.
REQ-035 ARESETN deassertion is synchronised to ACLK by the integrating top level.

Structure
REQ-036 Package servo_seq_pkg SHALL hold the state enum, RESP_OKAY=2'b00, REG_STRIDE=4 and TIMEOUT_W=8. The block is a single module with no sub-module; the timeout counter is inline.

Verification
REQ-037 Always-ready slave register bank, servo_data words 1,2,3,4, start -> writes 0x1..0x4 to 0x0/0x4/0x8/0xC, reads return them, one done pulse, err=0, mismatch=4'b0000.
REQ-038 AWREADY delayed 3 cycles with WREADY immediate -> WVALID drops after its handshake, AWVALID and AWADDR held stable until accepted; final result as REQ-037.
REQ-039 Slave returns BRESP=2'b10 on register 2 -> all 4 reads still issued, err=1 at done, mismatch=0.
REQ-040 Slave returns 0xDEADBEEF for register 3 -> mismatch=4'b1000, err=0.
REQ-041 ARREADY held 0 -> after 255 wait cycles ARVALID=0, err=1, done pulse; a following start clears err and the update completes clean.
REQ-042 ARESETN low during WRESP -> all outputs 0 immediately; start after release performs a full, correct update.
